// File: rtl/muldiv_seq_pkg.sv
// Shared definitions for the multiply/divide sequencer: command encodings,
// FSM state encoding and a conditional two's-complement magnitude helper.
package muldiv_seq_pkg;

  localparam logic [2:0] MD_OP_MULT  = 3'd0;
  localparam logic [2:0] MD_OP_MULTU = 3'd1;
  localparam logic [2:0] MD_OP_DIV   = 3'd2;
  localparam logic [2:0] MD_OP_DIVU  = 3'd3;
  localparam logic [2:0] MD_OP_MTHI  = 3'd4;
  localparam logic [2:0] MD_OP_MTLO  = 3'd5;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_DIV  = 2'd2
  } md_state_e;

  // 0x80000000 maps to itself and is then read as an unsigned 2^31.
  function automatic logic [31:0] md_abs(input logic [31:0] v, input logic en);
    return (en && v[31]) ? (~v + 32'd1) : v;
  endfunction

endpackage

// File: rtl/muldiv_seq_div_iter.sv
// Restoring divider datapath: one shift/trial-subtract step per enabled cycle.
// The quo_o/rem_o outputs are the result of the step taken at the coming edge.
module muldiv_seq_div_iter (
  input  logic        clk,
  input  logic        resetn,
  input  logic        load_i,
  input  logic        en_i,
  input  logic [31:0] dividend_i,
  input  logic [31:0] divisor_i,
  output logic [31:0] quo_o,
  output logic [31:0] rem_o
);

  logic [32:0] rem_q;
  logic [31:0] quo_q;
  logic [31:0] dvs_q;
  logic [33:0] rem_sh;
  logic [33:0] trial;
  logic        fits;
  logic [32:0] rem_d;
  logic [31:0] quo_d;

  assign rem_sh = {rem_q, quo_q[31]};
  assign trial  = rem_sh - {2'b00, dvs_q};
  assign fits   = ~trial[33];
  assign rem_d  = fits ? trial[32:0] : rem_sh[32:0];
  assign quo_d  = {quo_q[30:0], fits};
  assign quo_o  = quo_d;
  assign rem_o  = rem_d[31:0];

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      rem_q <= '0;
      quo_q <= '0;
      dvs_q <= '0;
    end else if (load_i) begin
      rem_q <= '0;
      quo_q <= dividend_i;
      dvs_q <= divisor_i;
    end else if (en_i) begin
      rem_q <= rem_d;
      quo_q <= quo_d;
    end
  end

endmodule

// File: rtl/muldiv_seq.sv
// Multi-cycle multiply/divide sequencer owning the architectural HI/LO registers.
// Stalls the pipeline via busy while a MULT/DIV is in flight; flush cancels with no partial write.
module muldiv_seq
  import muldiv_seq_pkg::*;
#(
  parameter int MUL_LAT  = 4,
  parameter int DIV_ITER = 32
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        start,
  input  logic [2:0]  op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        flush,
  output logic        busy,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  md_state_e   state_q, state_d;
  logic        busy_q;
  logic [4:0]  count_q, count_d;
  logic [31:0] hi_q, hi_d, lo_q, lo_d;
  logic [31:0] ma_q, ma_d, mb_q, mb_d;
  logic        msgn_q, msgn_d;
  logic        qneg_q, qneg_d, rneg_q, rneg_d, dz_q, dz_d;
  logic        div_load, div_en, div_signed;
  logic [31:0] div_quo, div_rem;
  logic [63:0] ma_ext, mb_ext, prod;

  // Sign-extended 64-bit operands: the low 64 bits of the product are exact either way.
  assign ma_ext     = {{32{msgn_q & ma_q[31]}}, ma_q};
  assign mb_ext     = {{32{msgn_q & mb_q[31]}}, mb_q};
  assign prod       = ma_ext * mb_ext;
  assign div_signed = (op == MD_OP_DIV);

  muldiv_seq_div_iter u_div (
    .clk        (clk),
    .resetn     (resetn),
    .load_i     (div_load),
    .en_i       (div_en),
    .dividend_i (md_abs(a, div_signed)),
    .divisor_i  (md_abs(b, div_signed)),
    .quo_o      (div_quo),
    .rem_o      (div_rem)
  );

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= ST_IDLE;
      busy_q  <= 1'b0;
      count_q <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      ma_q    <= '0;
      mb_q    <= '0;
      msgn_q  <= 1'b0;
      qneg_q  <= 1'b0;
      rneg_q  <= 1'b0;
      dz_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      busy_q  <= (state_d != ST_IDLE);
      count_q <= count_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      ma_q    <= ma_d;
      mb_q    <= mb_d;
      msgn_q  <= msgn_d;
      qneg_q  <= qneg_d;
      rneg_q  <= rneg_d;
      dz_q    <= dz_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (flush) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (start && (op == MD_OP_MULT || op == MD_OP_MULTU)) state_d = ST_MUL;
          if (start && (op == MD_OP_DIV || op == MD_OP_DIVU))   state_d = ST_DIV;
        end
        ST_MUL:  if (count_q == 5'd0) state_d = ST_IDLE;
        ST_DIV:  if (count_q == 5'd0) state_d = ST_IDLE;
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_comb begin
    hi_d     = hi_q;
    lo_d     = lo_q;
    count_d  = count_q;
    ma_d     = ma_q;
    mb_d     = mb_q;
    msgn_d   = msgn_q;
    qneg_d   = qneg_q;
    rneg_d   = rneg_q;
    dz_d     = dz_q;
    div_load = 1'b0;
    div_en   = 1'b0;
    if (flush) begin
      count_d = '0;
    end else begin
      case (state_q)
        ST_IDLE: if (start) begin
          case (op)
            MD_OP_MTHI: hi_d = a;
            MD_OP_MTLO: lo_d = a;
            MD_OP_MULT, MD_OP_MULTU: begin
              ma_d    = a;
              mb_d    = b;
              msgn_d  = (op == MD_OP_MULT);
              count_d = 5'(MUL_LAT - 1);
            end
            MD_OP_DIV, MD_OP_DIVU: begin
              qneg_d   = div_signed & (a[31] ^ b[31]);
              rneg_d   = div_signed & a[31];
              dz_d     = (b == 32'd0);
              count_d  = (b == 32'd0) ? 5'd0 : 5'(DIV_ITER - 1);
              div_load = 1'b1;
            end
            default: ;
          endcase
        end
        ST_MUL: begin
          count_d = count_q - 5'd1;
          if (count_q == 5'd0) begin
            count_d    = '0;
            {hi_d, lo_d} = prod;
          end
        end
        ST_DIV: begin
          div_en  = ~dz_q;
          count_d = count_q - 5'd1;
          if (count_q == 5'd0) begin
            count_d = '0;
            if (!dz_q) begin
              lo_d = qneg_q ? (~div_quo + 32'd1) : div_quo;
              hi_d = rneg_q ? (~div_rem + 32'd1) : div_rem;
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign busy = busy_q;
  assign hi   = hi_q;
  assign lo   = lo_q;

endmodule
